gf233_sqrtblk: RTL and testbench



---
 rtl/gf233_pkg.sv | 37 +++
 rtl/gf233_sqrt.sv | 35 +++
 rtl/gf233_sqrtblk.sv | 104 ++++++++++
 tb/tb_gf233_sqrtblk.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/gf233_pkg.sv
// Shared GF(2^233) definitions, f(x) = x^233 + x^74 + 1: field constants, element
// types, controller state encoding and the polynomial reduction helper.
package gf233_pkg;

  localparam int M    = 233;
  localparam int TAP  = 74;
  localparam int SELW = 4;

  typedef logic [M-1:0]   elem_t;
  typedef logic [2*M-2:0] wide_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // sqrt(x) = x^(2^232) mod f = x^228 + x^191 + x^154 + x^117 + x^69 + x^32
  localparam elem_t SQRT_X = (elem_t'(1) << 228) | (elem_t'(1) << 191) |
                             (elem_t'(1) << 154) | (elem_t'(1) << 117) |
                             (elem_t'(1) << 69)  | (elem_t'(1) << 32);

  // Folds every bit at or above x^233 back onto x^(i-233+74) and x^(i-233).
  function automatic elem_t gf_reduce(input wide_t p);
    wide_t r;
    logic  b;
    r = p;
    for (int i = 2*M-2; i >= M; i--) begin
      b = r[i];
      r[i] = 1'b0;
      r[i-M+TAP] = r[i-M+TAP] ^ b;
      r[i-M] = r[i-M] ^ b;
    end
    return r[M-1:0];
  endfunction

endpackage

// File: rtl/gf233_sqrt.sv
// Single combinational GF(2^233) square root: sqrt(a) = E(a) + SQRT_X * O(a) mod f,
// where E/O collect the even/odd indexed coefficients of a.
module gf233_sqrt
  import gf233_pkg::*;
(
  input  logic [M-1:0] in,
  output logic [M-1:0] out
);

  elem_t even_s;
  elem_t odd_s;
  wide_t prod_s;

  // Coefficient split followed by the constant-operand XOR product and reduction.
  always_comb begin
    even_s = '0;
    odd_s  = '0;
    prod_s = '0;
    for (int i = 0; i < 117; i++) begin
      even_s[i] = in[2*i];
    end
    for (int i = 0; i < 116; i++) begin
      odd_s[i] = in[2*i+1];
    end
    for (int j = 0; j < M; j++) begin
      if (SQRT_X[j]) begin
        prod_s = prod_s ^ (wide_t'(odd_s) << j);
      end else begin
        prod_s = prod_s;
      end
    end
    out = gf_reduce(prod_s ^ wide_t'(even_s));
  end

endmodule

// File: rtl/gf233_sqrtblk.sv
// Iterative engine returning in^(2^-sel): one square root per cycle under a
// start/busy/done handshake. Optional SQRT_ZERO_FAST_EN short-circuits zero operands.
module gf233_sqrtblk
  import gf233_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [M-1:0]    in,
  input  logic [SELW-1:0] sel,
  output logic            busy,
  output logic            done,
  output logic [M-1:0]    out
);

  state_t          state_r;
  state_t          state_s;
  elem_t           acc_r;
  elem_t           root_s;
  logic [SELW-1:0] cnt_r;
  logic            zero_go_s;

  gf233_sqrt u_sqrt (
    .in  (acc_r),
    .out (root_s)
  );

`ifdef SQRT_ZERO_FAST_EN
  assign zero_go_s = (in == '0);
`else
  assign zero_go_s = 1'b0;
`endif

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if ((sel == 4'd0) || zero_go_s) begin
            state_s = FIN;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == 4'd1) begin
          state_s = FIN;
        end else begin
          state_s = RUN;
        end
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs; done/out load on the edge entering FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= '0;
      cnt_r   <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      out     <= '0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r <= in;
            cnt_r <= sel;
            busy  <= 1'b1;
            if (state_s == FIN) begin
              done <= 1'b1;
              out  <= in;
            end
          end
        end
        RUN: begin
          acc_r <= root_s;
          cnt_r <= cnt_r - 4'd1;
          if (state_s == FIN) begin
            done <= 1'b1;
            out  <= root_s;
          end
        end
        FIN: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf233_sqrtblk.sv
// Randomized self-checking bench for gf233_sqrtblk against a Frobenius-power model.
module tb_gf233_sqrtblk;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [232:0] in = '0;
  logic [3:0]   sel = 4'd0;
  logic         busy;
  logic         done;
  logic [232:0] out;

  int total = 0;
  int bad = 0;

  gf233_sqrtblk dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (in),
    .sel   (sel),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [232:0] act, input logic [232:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Squaring in GF(2^233): spread bits, then fold x^i (i>=233) onto x^(i-233)+x^(i-159).
  function automatic logic [232:0] sq(input logic [232:0] a);
    logic [465:0] p;
    p = '0;
    for (int i = 0; i < 233; i++) p[2*i] = a[i];
    for (int i = 464; i >= 233; i--) begin
      if (p[i]) begin
        p[i] = 1'b0;
        p[i-233] = ~p[i-233];
        p[i-159] = ~p[i-159];
      end
    end
    return p[232:0];
  endfunction

  function automatic logic [232:0] sq_n(input logic [232:0] a, input int n);
    logic [232:0] r;
    r = a;
    for (int i = 0; i < n; i++) r = sq(r);
    return r;
  endfunction

  // a^(2^233) = a, so k square roots equal 233-k squarings.
  function automatic logic [232:0] sqrt_k(input logic [232:0] a, input int k);
    return sq_n(a, 233 - k);
  endfunction

  function automatic logic [232:0] rnd();
    logic [255:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    return t[232:0];
  endfunction

  // Compare process: tracks acceptance from sampled inputs and checks every cycle.
  initial begin
    int e, acc_e, acc_k, idle_from, orig_k;
    logic have;
    logic s_rst, s_start;
    logic [232:0] s_in, ma, mexp, exp_out;
    logic [3:0] s_sel;
    logic exp_done, exp_busy;
    e = 0; acc_e = 0; acc_k = 0; idle_from = 0; orig_k = 0;
    have = 1'b0; ma = '0; mexp = '0; exp_out = '0;
    forever begin
      @(posedge clk);
      s_rst = rst; s_start = start; s_in = in; s_sel = sel;
      e++;
      if (s_rst) begin
        have = 1'b0;
        exp_out = '0;
        idle_from = e + 1;
      end else if (s_start && e >= idle_from) begin
        have = 1'b1;
        acc_e = e;
        orig_k = int'(s_sel);
        acc_k = orig_k;
`ifdef SQRT_ZERO_FAST_EN
        if (s_in == '0) acc_k = 0;
`endif
        ma = s_in;
        mexp = sqrt_k(s_in, orig_k);
        idle_from = e + acc_k + 2;
      end
      #1;
      exp_done = have && (e == acc_e + acc_k);
      exp_busy = have && (e >= acc_e) && (e <= acc_e + acc_k);
      if (exp_done) exp_out = mexp;
      chk("done", 233'(done), 233'(exp_done));
      chk("busy", 233'(busy), 233'(exp_busy));
      chk("out", out, exp_out);
      if (exp_done && done) chk("inverse", sq_n(out, orig_k), ma);
    end
  end

  task automatic wait_done(output int waited);
    waited = 0;
    while (!done && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout waiting for done after %0d cycles", waited);
    end
  endtask

  task automatic op(input logic [232:0] a, input logic [3:0] k, output int lat);
    @(negedge clk);
    start = 1'b1; in = a; sel = k;
    @(negedge clk);
    start = 1'b0; in = rnd(); sel = 4'($urandom_range(15, 0));
    wait_done(lat);
  endtask

  initial begin
    int lat;
    logic [232:0] r;

    chk("model_sq_x", sq(233'h2), 233'h4);
    r = (233'd1 << 75) | 233'h2;
    chk("model_sq_x117", sq(233'd1 << 117), r);
    chk("model_sqrt_x2", sqrt_k(233'h4, 1), 233'h2);
    chk("sqrt_x_const", sq(gf233_pkg::SQRT_X), 233'h2);

    repeat (3) @(negedge clk);
    rst = 1'b0;

    op(233'h4, 4'd1, lat);
    chk("x2_out", out, 233'h2);
    chk("x2_lat", 233'(lat), 233'd1);
    @(negedge clk);
    chk("x2_busy_after", 233'(busy), 233'd0);

    op(233'h1, 4'd15, lat);
    chk("one_out", out, 233'h1);
    chk("one_lat", 233'(lat), 233'd15);

    r = rnd();
    op(r, 4'd0, lat);
    chk("sel0_out", out, r);
    chk("sel0_lat", 233'(lat), 233'd0);
    @(negedge clk);
    chk("sel0_pulse", 233'(done), 233'd0);

    op(233'h0, 4'd9, lat);
    chk("zero_out", out, 233'h0);
`ifdef SQRT_ZERO_FAST_EN
    chk("zero_lat", 233'(lat), 233'd0);
`else
    chk("zero_lat", 233'(lat), 233'd9);
`endif

    op({233{1'b1}}, 4'd15, lat);

    // start held high with changing operands through a sel=5 run
    r = rnd();
    @(negedge clk);
    start = 1'b1; in = r; sel = 4'd5;
    repeat (6) begin
      @(negedge clk);
      in = rnd(); sel = 4'($urandom_range(15, 0));
    end
    @(negedge clk);
    start = 1'b0;
    chk("spam_out", out, sqrt_k(r, 5));

    // reset in the middle of a run
    @(negedge clk);
    start = 1'b1; in = rnd(); sel = 4'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 233'(busy), 233'd0);
    chk("rst_done", 233'(done), 233'd0);
    chk("rst_out", out, 233'd0);
    repeat (12) @(negedge clk);

    for (int n = 0; n < 1000; n++) begin
      op(rnd(), 4'($urandom_range(15, 1)), lat);
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
